uart_parse_hanoi: RTL and testbench
===================================

Name: uart_parse_hanoi

Overview:
Receive-side formatter for the UART console. It takes bytes from the UART receiver and parses ASCII decimal lines terminated by CR or LF. Each valid line is presented as a binary value to the MIPS input port (PIN instruction) through a ready/ack handshake. This block is the input counterpart of the POUT-to-UART output formatter, so the user can type, for example, the Hanoi disk count at run time.

Parameters:
WIDTH, 8, bit width of the parsed value; the maximum accepted value is 2^WIDTH-1.
MAX_DIGITS, 3, maximum digit characters per line; more than this is an error.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
rx_valid  input  1  one-cycle pulse from the UART receiver; rx_data is valid in that cycle
rx_data  input  8  received byte
rd_ack  input  1  one-cycle pulse from the CPU input-port logic; consumes the presented value
data_out  output  WIDTH  parsed value; meaningful only while data_ready=1
data_ready  output  1  a parsed value is waiting for the CPU
parse_err  output  1  one-cycle pulse when a malformed line is terminated
overrun  output  1  sticky flag: a byte arrived and was dropped while data_ready=1

Behaviour:
- All outputs are registered.
- Reset (asynchronous, rst=0), including mid-line or mid-READY:
  - state=IDLE; accumulator, digit count, data_out, data_ready, parse_err and overrun all go to 0.
  - Any partial line is discarded.
- Byte classes:
  - DIGIT: 0x30-0x39, value d = rx_data-0x30.
  - TERM: 0x0D or 0x0A.
  - OTHER: any remaining byte.
- States: IDLE (no digits yet), ACCUM (at least one digit), READY (value presented), ERROR (discarding until TERM).
- The FSM acts only in cycles where rx_valid=1, except for READY/ack handling.
- IDLE:
  - DIGIT: acc<=d, cnt<=1, go to ACCUM.
  - TERM: ignored, so a CR LF pair or a blank line produces nothing.
  - OTHER: go to ERROR.
- ACCUM:
  - DIGIT: compute nxt = acc*10 + d in WIDTH+4 bits.
    - If cnt==MAX_DIGITS or nxt > 2^WIDTH-1: go to ERROR.
    - Otherwise acc<=nxt[WIDTH-1:0] and cnt<=cnt+1.
  - TERM: data_out<=acc, data_ready<=1, go to READY. data_ready rises on the clock edge that samples the TERM byte, so it is visible the next cycle.
  - OTHER: go to ERROR.
- ERROR:
  - DIGIT and OTHER are ignored.
  - TERM: parse_err=1 for exactly one cycle, acc and cnt cleared, go to IDLE.
- READY:
  - data_out and data_ready are held stable until rd_ack.
  - rx_valid without rd_ack: the byte is dropped and overrun<=1.
  - rd_ack: data_ready<=0, overrun<=0, acc and cnt cleared, go to IDLE.
  - rd_ack and rx_valid in the same cycle: the byte is not dropped. It is processed exactly as in IDLE in that same cycle (DIGIT goes to ACCUM with acc=d; TERM is ignored; OTHER goes to ERROR), and overrun is cleared.
- rd_ack outside READY is ignored and has no effect.
- After an ack, data_out keeps its last value; consumers must qualify it with data_ready.
- Latency:
  - TERM byte to data_ready=1: 1 clock.
  - rd_ack to data_ready=0: 1 clock.
  - TERM byte to parse_err pulse: 1 clock.
- Leading zeros count toward cnt ("007" is valid when MAX_DIGITS=3; "0007" is an error).
- Only one value is buffered; there is no FIFO.

Test Plan:
- Reset, then rx "1","2","3",0x0D → data_ready=1 with data_out=8'd123 one cycle after CR; held 20 cycles; rd_ack → data_ready=0 the next cycle.
- rx "7",0x0D,0x0A → exactly one value, 7; the LF in IDLE produces neither data_ready nor parse_err.
- rx "2","5","6",0x0D (WIDTH=8) → no data_ready; parse_err pulses high for exactly 1 cycle after CR. Then rx "1","0","0","0",0x0D → parse_err (digit limit). Then "0","0","7",0x0D → data_out=7.
- rx "4","x","5",0x0D → parse_err pulse, data_ready stays 0. Then "5",0x0A → data_out=5, data_ready=1.
- While READY with value 9: rx "3" with no ack → overrun=1 and data_out stays 9. Then rd_ack together with rx "8", followed by 0x0D → overrun=0, then data_ready=1 with data_out=8.
- rx "4","2", then assert rst=0 mid-line, release, rx "6",0x0D → data_out=6 (partial "42" discarded); all outputs read 0 during reset.

Source files
------------

// File: rtl/uart_parse_hanoi_if.sv
// Byte-in / value-out handshake bundle between the UART receiver, the line
// parser and the CPU input-port logic.
interface uart_parse_hanoi_if #(
  parameter int WIDTH = 8
);
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rd_ack;
  logic [WIDTH-1:0] data_out;
  logic             data_ready;
  logic             parse_err;
  logic             overrun;

  modport master (
    output rx_valid, rx_data, rd_ack,
    input  data_out, data_ready, parse_err, overrun
  );

  modport slave (
    input  rx_valid, rx_data, rd_ack,
    output data_out, data_ready, parse_err, overrun
  );
endinterface

// File: rtl/uart_parse_hanoi.sv
// Parses CR/LF-terminated ASCII decimal lines from the UART receiver and holds
// each valid value for the CPU input port until it is acknowledged.
module uart_parse_hanoi #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst,
  uart_parse_hanoi_if.slave bus
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(MAX_DIGITS);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);
  localparam logic [WIDTH+3:0] VAL_MAX = {4'b0000, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    READY = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] data_out_r;
  logic             data_ready_r;
  logic             parse_err_r;
  logic             overrun_r;

  logic             is_digit_s;
  logic             is_term_s;
  logic [3:0]       digit_s;
  logic [WIDTH+3:0] acc_wide_s;
  logic [WIDTH+3:0] nxt_s;
  logic             too_long_s;

  // Byte classification and the acc*10+d step, kept wide enough to see overflow.
  always_comb begin
    is_digit_s = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    is_term_s  = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
    digit_s    = bus.rx_data[3:0];
    acc_wide_s = {4'b0000, acc_r};
    nxt_s      = (acc_wide_s << 2'd3) + (acc_wide_s << 2'd1) + {{WIDTH{1'b0}}, digit_s};
    if (cnt_r == CNT_MAX) begin
      too_long_s = 1'b1;
    end else begin
      too_long_s = 1'b0;
    end
  end

  // Line-parsing FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      acc_r        <= {WIDTH{1'b0}};
      cnt_r        <= {CW{1'b0}};
      data_out_r   <= {WIDTH{1'b0}};
      data_ready_r <= 1'b0;
      parse_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      parse_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.rx_valid) begin
            if (is_digit_s) begin
              acc_r   <= WIDTH'(digit_s);
              cnt_r   <= CNT_ONE;
              state_r <= ACCUM;
            end else if (!is_term_s) begin
              state_r <= ERROR;
            end else begin
              state_r <= IDLE;
            end
          end
        end
        ACCUM: begin
          if (bus.rx_valid) begin
            if (is_digit_s) begin
              if (too_long_s || (nxt_s > VAL_MAX)) begin
                state_r <= ERROR;
              end else begin
                acc_r <= nxt_s[WIDTH-1:0];
                cnt_r <= cnt_r + CNT_ONE;
              end
            end else if (is_term_s) begin
              data_out_r   <= acc_r;
              data_ready_r <= 1'b1;
              state_r      <= READY;
            end else begin
              state_r <= ERROR;
            end
          end
        end
        READY: begin
          if (bus.rd_ack) begin
            data_ready_r <= 1'b0;
            overrun_r    <= 1'b0;
            acc_r        <= {WIDTH{1'b0}};
            cnt_r        <= {CW{1'b0}};
            state_r      <= IDLE;
            // A byte arriving with the ack starts the next line immediately.
            if (bus.rx_valid) begin
              if (is_digit_s) begin
                acc_r   <= WIDTH'(digit_s);
                cnt_r   <= CNT_ONE;
                state_r <= ACCUM;
              end else if (!is_term_s) begin
                state_r <= ERROR;
              end else begin
                state_r <= IDLE;
              end
            end
          end else if (bus.rx_valid) begin
            overrun_r <= 1'b1;
          end else begin
            overrun_r <= overrun_r;
          end
        end
        ERROR: begin
          if (bus.rx_valid && is_term_s) begin
            parse_err_r <= 1'b1;
            acc_r       <= {WIDTH{1'b0}};
            cnt_r       <= {CW{1'b0}};
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.data_ready = data_ready_r;
  assign bus.parse_err  = parse_err_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_uart_parse_hanoi.sv
// Self-checking bench for uart_parse_hanoi: directed vector table, hand-written
// reset/hold sequences and random traffic against a line-level reference model.
module tb_uart_parse_hanoi;

  localparam int WIDTH      = 8;
  localparam int MAX_DIGITS = 3;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  logic clk;
  logic rst;
  uart_parse_hanoi_if #(.WIDTH(WIDTH)) bus ();

  uart_parse_hanoi #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: collects the whole line and judges it when the terminator arrives.
  logic [7:0] m_line[$];
  logic       m_ready;
  logic [7:0] m_dout;
  logic       m_perr;
  logic       m_ovr;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       a;
    logic       rdy;
    logic [7:0] dout;
    logic       perr;
    logic       ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_line.delete();
    m_ready = 1'b0;
    m_dout  = 8'd0;
    m_perr  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] d);
    int  val;
    bit  ok;
    if (d == CR || d == LF) begin
      if (m_line.size() != 0) begin
        ok  = 1'b1;
        val = 0;
        foreach (m_line[i]) begin
          if (m_line[i] < 8'h30 || m_line[i] > 8'h39) ok = 1'b0;
          else if (val < 100000) val = val * 10 + int'(m_line[i] - 8'h30);
        end
        if (m_line.size() > MAX_DIGITS) ok = 1'b0;
        if (val > (1 << WIDTH) - 1) ok = 1'b0;
        if (ok) begin
          m_ready = 1'b1;
          m_dout  = val[7:0];
        end else begin
          m_perr = 1'b1;
        end
        m_line.delete();
      end
    end else begin
      m_line.push_back(d);
    end
  endtask

  task automatic model_update(input logic v, input logic [7:0] d, input logic a);
    m_perr = 1'b0;
    if (m_ready) begin
      if (a) begin
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_line.delete();
        if (v) model_byte(d);
      end else if (v) begin
        m_ovr = 1'b1;
      end
    end else if (v) begin
      model_byte(d);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic a);
    @(negedge clk);
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.rd_ack   = a;
    @(posedge clk);
    model_update(v, d, a);
    #1;
    chk("model_ready", bus.data_ready, m_ready);
    chk("model_dout",  bus.data_out,   m_dout);
    chk("model_perr",  bus.parse_err,  m_perr);
    chk("model_ovr",   bus.overrun,    m_ovr);
    bus.rx_valid = 1'b0;
    bus.rd_ack   = 1'b0;
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic a,
                     input logic rdy, input logic [7:0] dout, input logic perr, input logic ovr);
    vec_t e;
    e.v = v; e.d = d; e.a = a; e.rdy = rdy; e.dout = dout; e.perr = perr; e.ovr = ovr;
    tbl.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, bus.data_ready, 32'd0);
    chk({tag, "_dout"},  bus.data_out,   32'd0);
    chk({tag, "_perr"},  bus.parse_err,  32'd0);
    chk({tag, "_ovr"},   bus.overrun,    32'd0);
  endtask

  initial begin
    logic       v;
    logic [7:0] d;
    logic       a;
    int         sel;

    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rd_ack   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // v, byte, ack, expected ready, data_out, parse_err, overrun after the edge
    add(1'b1, 8'h31, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h32, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h33, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, CR,    1'b0, 1'b1, 8'd123, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 8'd123, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h37, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, CR,    1'b0, 1'b1, 8'd7,   1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, LF,    1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h32, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h35, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h36, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, CR,    1'b0, 1'b0, 8'd0,   1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h31, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h30, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h30, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h30, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, CR,    1'b0, 1'b0, 8'd0,   1'b1, 1'b0);
    add(1'b1, 8'h30, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h30, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h37, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, CR,    1'b0, 1'b1, 8'd7,   1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h34, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h78, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h35, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, CR,    1'b0, 1'b0, 8'd0,   1'b1, 1'b0);
    add(1'b1, 8'h35, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, LF,    1'b0, 1'b1, 8'd5,   1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, 8'h39, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, CR,    1'b0, 1'b1, 8'd9,   1'b0, 1'b0);
    add(1'b1, 8'h33, 1'b0, 1'b1, 8'd9,   1'b0, 1'b1);
    add(1'b1, 8'h38, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0);
    add(1'b1, CR,    1'b0, 1'b1, 8'd8,   1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 8'd0,   1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].a);
      chk($sformatf("vec%0d_ready", i), bus.data_ready, tbl[i].rdy);
      chk($sformatf("vec%0d_perr", i),  bus.parse_err,  tbl[i].perr);
      chk($sformatf("vec%0d_ovr", i),   bus.overrun,    tbl[i].ovr);
      if (tbl[i].rdy) chk($sformatf("vec%0d_dout", i), bus.data_out, tbl[i].dout);
    end

    // Value must hold steady for 20 idle cycles, then drop one cycle after ack.
    step(1'b1, 8'h31, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, CR,    1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("hold_ready", bus.data_ready, 32'd1);
      chk("hold_dout",  bus.data_out,   32'd123);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("ack_ready", bus.data_ready, 32'd0);

    // Asynchronous reset while READY with overrun set clears everything.
    step(1'b1, 8'h39, 1'b0);
    step(1'b1, CR,    1'b0);
    step(1'b1, 8'h31, 1'b0);
    chk("pre_rst_ovr", bus.overrun, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    check_zero("held_rst");
    rst = 1'b1;

    // Reset in the middle of a line discards the partial digits.
    step(1'b1, 8'h34, 1'b0);
    step(1'b1, 8'h32, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("midline_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'h36, 1'b0);
    step(1'b1, CR,    1'b0);
    chk("after_rst_ready", bus.data_ready, 32'd1);
    chk("after_rst_dout",  bus.data_out,   32'd6);
    step(1'b0, 8'h00, 1'b1);

    // Random traffic checked against the line-level model.
    for (int i = 0; i < 4000; i++) begin
      v   = ($urandom_range(0, 99) < 60);
      sel = $urandom_range(0, 99);
      if (sel < 35)      d = 8'h30 + 8'($urandom_range(0, 2));
      else if (sel < 60) d = 8'h30 + 8'($urandom_range(0, 9));
      else if (sel < 80) d = ($urandom_range(0, 1) == 0) ? CR : LF;
      else               d = 8'($urandom_range(0, 255));
      if (m_ready) a = ($urandom_range(0, 3) == 0);
      else         a = ($urandom_range(0, 9) == 0);
      step(v, d, a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
